// File: rtl/drive_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// drive_cmd_arbiter
//
// Decides which command source (manual or autonomous) drives the car's UART
// command link. It also turns the owner's 6-bit command into the 8-bit UART
// command byte.
//
// Ownership FSM:
//   IDLE   (00) nobody owns the link and the byte is neutral (8'h80).
//   MANUAL (01) the manual source owns the link.
//   AUTO   (10) the auto source owns the link, guarded by a heartbeat watchdog.
//   GAP    (11) a forced neutral gap before manual takes over from auto.
//
// Command shaping:
//   - Motion bits pass as levels. Opposing pairs (fwd/back, left/right) that
//     are both set cancel to 0.
//   - place and destroy are rising-edge triggered one-shots. Each lasts exactly
//     PULSE_CYCLES cycles. Only one barrier pulse can be active at a time, and
//     place wins over destroy when both rise in the same cycle.
//
// Parameters:
//   PULSE_CYCLES    length of a place/destroy one-shot, in cycles
//   GAP_CYCLES      length of the neutral gap on an auto -> manual handover
//   TIMEOUT_CYCLES  consecutive heartbeat-free cycles in AUTO before giving up
//
// Ports:
//   sys_clk       system clock (single clock domain)
//   rst           asynchronous active-low reset
//   power_ok      car is drivable; when low, forces IDLE and a neutral byte
//   man_req       manual source ownership request (level)
//   man_cmd[5:0]  manual command {destroy, place, right, left, back, fwd}
//   auto_enable   auto mode permitted
//   auto_req      auto source ownership request (level)
//   auto_cmd[5:0] auto command, same layout as man_cmd
//   auto_alive    auto heartbeat pulse
//   man_gnt       registered: manual owns the link
//   auto_gnt      registered: auto owns the link
//   owner[1:0]    current FSM state encoding
//   cmd_out[7:0]  registered UART byte {2'b10, destroy, place, right, left,
//                 back, fwd}
//   timeout_flag  sticky watchdog expiry; cleared once auto_req drops
// -----------------------------------------------------------------------------
module drive_cmd_arbiter #(
    parameter int unsigned PULSE_CYCLES   = 2000000,
    parameter int unsigned GAP_CYCLES     = 1000000,
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       power_ok,
    input  logic       man_req,
    input  logic [5:0] man_cmd,
    input  logic       auto_enable,
    input  logic       auto_req,
    input  logic [5:0] auto_cmd,
    input  logic       auto_alive,
    output logic       man_gnt,
    output logic       auto_gnt,
    output logic [1:0] owner,
    output logic [7:0] cmd_out,
    output logic       timeout_flag
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_MANUAL = 2'b01,
        ST_AUTO   = 2'b10,
        ST_GAP    = 2'b11
    } state_t;

    localparam int unsigned PW = $clog2(PULSE_CYCLES + 1);
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);

    // Counters load "cycles remaining after this one", so they count down to 0.
    localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP_CYCLES - 1);
    localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] NEUTRAL_CMD = 8'b1000_0000;

    // Builds the UART command byte from the shaped command bits.
    function automatic logic [7:0] pack_cmd(
        input logic destroy,
        input logic place,
        input logic right,
        input logic left,
        input logic back,
        input logic fwd
    );
        return {2'b10, destroy, place, right, left, back, fwd};
    endfunction

    // Flops
    state_t          state_q,        state_d;
    state_t          gap_tgt_q,      gap_tgt_d;
    logic [GW-1:0]   gap_cnt_q,      gap_cnt_d;
    logic [WW-1:0]   wd_cnt_q,       wd_cnt_d;
    logic            timeout_q,      timeout_d;
    logic [PW-1:0]   pulse_cnt_q,    pulse_cnt_d;
    logic            pulse_place_q,  pulse_place_d;
    logic            prev_place_q,   prev_place_d;
    logic            prev_destroy_q, prev_destroy_d;
    logic [7:0]      cmd_out_q,      cmd_out_d;
    logic            man_gnt_q,      man_gnt_d;
    logic            auto_gnt_q,     auto_gnt_d;

    // Combinational helpers
    logic            wd_fire_s;
    logic            gap_tgt_req_s;
    logic            owning_s;
    logic [5:0]      owned_cmd_s;
    logic            place_rise_s;
    logic            destroy_rise_s;
    logic            place_on_s;
    logic            destroy_on_s;

    // Watchdog expiry: the current AUTO cycle is the TIMEOUT_CYCLES-th in a
    // row without a heartbeat, and no higher-priority exit is being taken.
    always_comb begin
        wd_fire_s = power_ok && (state_q == ST_AUTO) && !man_req &&
                    !auto_alive && (wd_cnt_q == WD_LAST);
    end

    // The gap target is entered only if its request is still standing when
    // the gap ends.
    always_comb begin
        if (gap_tgt_q == ST_MANUAL) begin
            gap_tgt_req_s = man_req;
        end else begin
            gap_tgt_req_s = auto_enable && auto_req && !timeout_q;
        end
    end

    // Ownership FSM next-state logic, including the gap counter.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        gap_tgt_d = gap_tgt_q;
        if (!power_ok) begin
            state_d   = ST_IDLE;
            gap_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (man_req) begin
                        state_d = ST_MANUAL;
                    end else if (auto_enable && auto_req && !timeout_q) begin
                        state_d = ST_AUTO;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_MANUAL: begin
                    if (!man_req) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_MANUAL;
                    end
                end
                ST_AUTO: begin
                    if (man_req) begin
                        // Manual preempts auto, but only after a neutral gap.
                        state_d   = ST_GAP;
                        gap_cnt_d = GAP_LOAD;
                        gap_tgt_d = ST_MANUAL;
                    end else if (wd_fire_s) begin
                        state_d = ST_IDLE;
                    end else if (!auto_req || !auto_enable) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_AUTO;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == '0) begin
                        if (gap_tgt_req_s) begin
                            state_d = gap_tgt_q;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q - GW'(1);
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    gap_cnt_d = '0;
                end
            endcase
        end
    end

    // Heartbeat counter and sticky timeout flag.
    always_comb begin
        if ((state_q == ST_AUTO) && (state_d == ST_AUTO) && !auto_alive) begin
            wd_cnt_d = wd_cnt_q + WW'(1);
        end else begin
            wd_cnt_d = '0;
        end
        if (!auto_req) begin
            timeout_d = 1'b0;
        end else if (wd_fire_s) begin
            timeout_d = 1'b1;
        end else begin
            timeout_d = timeout_q;
        end
    end

    // Grants follow the state being entered, so they line up with owner.
    always_comb begin
        man_gnt_d  = (state_d == ST_MANUAL);
        auto_gnt_d = (state_d == ST_AUTO);
    end

    // Command shaping. The owner's command is used only while the owning state
    // is kept. On any exit the byte goes neutral at the same edge and the
    // pulse is dropped. Outside ownership, edge history is held "high", so a
    // level already present at grant time is not mistaken for a fresh edge.
    always_comb begin
        owning_s       = ((state_q == ST_MANUAL) || (state_q == ST_AUTO)) &&
                         (state_d == state_q);
        owned_cmd_s    = (state_q == ST_AUTO) ? auto_cmd : man_cmd;
        place_rise_s   = 1'b0;
        destroy_rise_s = 1'b0;
        place_on_s     = 1'b0;
        destroy_on_s   = 1'b0;
        pulse_cnt_d    = '0;
        pulse_place_d  = pulse_place_q;
        prev_place_d   = 1'b1;
        prev_destroy_d = 1'b1;
        cmd_out_d      = NEUTRAL_CMD;
        if (owning_s) begin
            place_rise_s   = owned_cmd_s[4] && !prev_place_q;
            destroy_rise_s = owned_cmd_s[5] && !prev_destroy_q;
            prev_place_d   = owned_cmd_s[4];
            prev_destroy_d = owned_cmd_s[5];
            if (pulse_cnt_q != '0) begin
                // A pulse is running: keep it and ignore any new edge.
                pulse_cnt_d  = pulse_cnt_q - PW'(1);
                place_on_s   = pulse_place_q;
                destroy_on_s = !pulse_place_q;
            end else if (place_rise_s) begin
                pulse_cnt_d   = PULSE_LOAD;
                pulse_place_d = 1'b1;
                place_on_s    = 1'b1;
            end else if (destroy_rise_s) begin
                pulse_cnt_d   = PULSE_LOAD;
                pulse_place_d = 1'b0;
                destroy_on_s  = 1'b1;
            end else begin
                pulse_cnt_d = '0;
            end
            cmd_out_d = pack_cmd(destroy_on_s,
                                 place_on_s,
                                 owned_cmd_s[3] && !owned_cmd_s[2],
                                 owned_cmd_s[2] && !owned_cmd_s[3],
                                 owned_cmd_s[1] && !owned_cmd_s[0],
                                 owned_cmd_s[0] && !owned_cmd_s[1]);
        end else begin
            pulse_cnt_d = '0;
            cmd_out_d   = NEUTRAL_CMD;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            gap_tgt_q      <= ST_IDLE;
            gap_cnt_q      <= '0;
            wd_cnt_q       <= '0;
            timeout_q      <= 1'b0;
            pulse_cnt_q    <= '0;
            pulse_place_q  <= 1'b0;
            prev_place_q   <= 1'b0;
            prev_destroy_q <= 1'b0;
            cmd_out_q      <= NEUTRAL_CMD;
            man_gnt_q      <= 1'b0;
            auto_gnt_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            gap_tgt_q      <= gap_tgt_d;
            gap_cnt_q      <= gap_cnt_d;
            wd_cnt_q       <= wd_cnt_d;
            timeout_q      <= timeout_d;
            pulse_cnt_q    <= pulse_cnt_d;
            pulse_place_q  <= pulse_place_d;
            prev_place_q   <= prev_place_d;
            prev_destroy_q <= prev_destroy_d;
            cmd_out_q      <= cmd_out_d;
            man_gnt_q      <= man_gnt_d;
            auto_gnt_q     <= auto_gnt_d;
        end
    end

    assign owner        = state_q;
    assign man_gnt      = man_gnt_q;
    assign auto_gnt     = auto_gnt_q;
    assign cmd_out      = cmd_out_q;
    assign timeout_flag = timeout_q;

endmodule

// File: tb/tb_drive_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_drive_cmd_arbiter
//
// Scoreboard bench for drive_cmd_arbiter (PULSE=4, GAP=3, TIMEOUT=10).
//
// The stimulus process drives inputs just after each falling edge. It then
// advances a behavioural model by one cycle and queues the outputs expected
// after the next rising edge. The model tracks pulse and gap end times and the
// start of the current heartbeat-free run against a free-running cycle count.
//
// A monitor pops one expectation at every falling edge and compares it with
// the DUT outputs.
//
// A reset blip is short and falls between rising edges. Because no rising edge
// sees rst low, the DUT shows the effect of the blip only if its reset is
// asynchronous.
// -----------------------------------------------------------------------------
module tb_drive_cmd_arbiter;

    localparam int P = 4;
    localparam int G = 3;
    localparam int T = 10;

    logic       sys_clk = 1'b0;
    logic       rst;
    logic       power_ok;
    logic       man_req;
    logic [5:0] man_cmd;
    logic       auto_enable;
    logic       auto_req;
    logic [5:0] auto_cmd;
    logic       auto_alive;
    logic       man_gnt;
    logic       auto_gnt;
    logic [1:0] owner;
    logic [7:0] cmd_out;
    logic       timeout_flag;

    always #5 sys_clk = ~sys_clk;

    drive_cmd_arbiter #(
        .PULSE_CYCLES   (P),
        .GAP_CYCLES     (G),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .power_ok     (power_ok),
        .man_req      (man_req),
        .man_cmd      (man_cmd),
        .auto_enable  (auto_enable),
        .auto_req     (auto_req),
        .auto_cmd     (auto_cmd),
        .auto_alive   (auto_alive),
        .man_gnt      (man_gnt),
        .auto_gnt     (auto_gnt),
        .owner        (owner),
        .cmd_out      (cmd_out),
        .timeout_flag (timeout_flag)
    );

    typedef struct packed {
        logic [1:0] own;
        logic       mg;
        logic       ag;
        logic [7:0] cmd;
        logic       tf;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Behavioural model state. Times are in model cycles.
    int   cyc          = 0;
    int   m_state      = 0;   // 0 idle, 1 manual, 2 auto, 3 gap
    int   m_pulse_end  = 0;   // pulse is active while cyc < m_pulse_end
    bit   m_pulse_pl   = 1'b0;
    int   m_gap_end    = 0;   // gap decision is taken at cyc == m_gap_end
    int   m_quiet_from = 0;   // first cycle of the current heartbeat-free run
    bit   m_last_pl    = 1'b0;
    bit   m_last_de    = 1'b0;
    bit   m_flag       = 1'b0;
    exp_t m_out;

    function automatic void model_reset();
        m_state     = 0;
        m_pulse_end = 0;
        m_gap_end   = 0;
        m_last_pl   = 1'b0;
        m_last_de   = 1'b0;
        m_flag      = 1'b0;
        m_out.own   = 2'b00;
        m_out.mg    = 1'b0;
        m_out.ag    = 1'b0;
        m_out.cmd   = 8'h80;
        m_out.tf    = 1'b0;
    endfunction

    function automatic void model_step();
        int         ns;
        bit         fire;
        bit         own;
        bit         pl;
        bit         de;
        logic [5:0] c;
        logic [7:0] co;
        fire = 1'b0;
        if (!power_ok) begin
            ns = 0;
        end else begin
            case (m_state)
                0: ns = man_req ? 1 : ((auto_enable && auto_req && !m_flag) ? 2 : 0);
                1: ns = man_req ? 1 : 0;
                2: begin
                    if (man_req) ns = 3;
                    else if (!auto_alive && (cyc - m_quiet_from + 1 == T)) begin
                        fire = 1'b1;
                        ns   = 0;
                    end else if (!auto_req || !auto_enable) ns = 0;
                    else ns = 2;
                end
                default: ns = (cyc >= m_gap_end) ? (man_req ? 1 : 0) : 3;
            endcase
        end
        own = ((m_state == 1) || (m_state == 2)) && (ns == m_state);
        c   = (m_state == 2) ? auto_cmd : man_cmd;
        pl  = 1'b0;
        de  = 1'b0;
        co  = 8'h80;
        if (own) begin
            if (cyc < m_pulse_end) begin
                pl = m_pulse_pl;
                de = !m_pulse_pl;
            end else if (c[4] && !m_last_pl) begin
                m_pulse_end = cyc + P;
                m_pulse_pl  = 1'b1;
                pl          = 1'b1;
            end else if (c[5] && !m_last_de) begin
                m_pulse_end = cyc + P;
                m_pulse_pl  = 1'b0;
                de          = 1'b1;
            end
            co = {2'b10, de, pl, c[3] & ~c[2], c[2] & ~c[3], c[1] & ~c[0], c[0] & ~c[1]};
            m_last_pl = c[4];
            m_last_de = c[5];
        end else begin
            m_pulse_end = 0;
            m_last_pl   = 1'b1;
            m_last_de   = 1'b1;
        end
        if (m_state == 2 && ns == 3) m_gap_end = cyc + G;
        if (ns == 2 && (m_state != 2 || auto_alive)) m_quiet_from = cyc + 1;
        if (!auto_req) m_flag = 1'b0;
        else if (fire) m_flag = 1'b1;
        m_out.own = 2'(ns);
        m_out.mg  = (ns == 1);
        m_out.ag  = (ns == 2);
        m_out.cmd = co;
        m_out.tf  = m_flag;
        m_state   = ns;
        cyc       = cyc + 1;
    endfunction

    // One cycle: update the model, queue the expectation, and move to the next
    // drive point.
    task automatic tick();
        if (!rst) model_reset();
        else model_step();
        sb_q.push_back(m_out);
        @(negedge sys_clk);
        #1;
    endtask

    // Short asynchronous reset pulse that does not overlap a rising edge.
    task automatic rst_blip();
        rst = 1'b0;
        #2;
        model_reset();
        rst = 1'b1;
        tick();
    endtask

    // Monitor: compare DUT outputs with the oldest queued expectation.
    always @(negedge sys_clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks = checks + 1;
            if ({owner, man_gnt, auto_gnt, cmd_out, timeout_flag} !== e) begin
                failures = failures + 1;
                $display("FAIL outputs t=%0t owner=%b exp=%b man_gnt=%b exp=%b auto_gnt=%b exp=%b cmd_out=%h exp=%h timeout_flag=%b exp=%b",
                         $time, owner, e.own, man_gnt, e.mg, auto_gnt, e.ag,
                         cmd_out, e.cmd, timeout_flag, e.tf);
            end
        end
    end

    // Global time limit so the bench can never hang.
    initial begin
        #1000000;
        $display("FAIL time_limit t=%0t checks=%0d", $time, checks);
        $fatal(1);
    end

    initial begin
        rst         = 1'b0;
        power_ok    = 1'b1;
        man_req     = 1'b0;
        man_cmd     = 6'b000000;
        auto_enable = 1'b0;
        auto_req    = 1'b0;
        auto_cmd    = 6'b000000;
        auto_alive  = 1'b0;
        repeat (3) tick();
        rst = 1'b1;

        // Manual grant with a forward command.
        man_req = 1'b1;
        man_cmd = 6'b000001;
        repeat (3) tick();

        // place edge, a second edge during the pulse, then a long hold.
        man_cmd = 6'b010001; tick();
        man_cmd = 6'b000001; tick();
        man_cmd = 6'b010001; repeat (20) tick();
        man_cmd = 6'b000001; tick();

        // Opposing motion bits cancel.
        man_cmd = 6'b001111; repeat (2) tick();

        // To IDLE, then AUTO with destroy already high at grant.
        man_req     = 1'b0; tick();
        auto_enable = 1'b1;
        auto_req    = 1'b1;
        auto_cmd    = 6'b100010;
        tick();
        repeat (3) begin
            auto_alive = 1'b1; tick();
            auto_alive = 1'b0; repeat (3) tick();
        end

        // destroy edge in AUTO, then manual preemption mid-pulse.
        auto_cmd   = 6'b000010; auto_alive = 1'b1; tick();
        auto_cmd   = 6'b100010; tick();
        auto_alive = 1'b0; tick();
        man_req = 1'b1;
        man_cmd = 6'b000100;
        repeat (6) tick();

        // Watchdog expiry, AUTO blocked while the flag is set, then re-entry.
        man_req = 1'b0; tick();
        repeat (14) tick();
        auto_req = 1'b0; repeat (2) tick();
        auto_req = 1'b1; repeat (4) tick();

        // Simultaneous requests from IDLE: manual wins.
        auto_req = 1'b0; man_req = 1'b0; repeat (2) tick();
        auto_req = 1'b1; man_req = 1'b1; repeat (3) tick();

        // Power loss in the middle of a place pulse.
        man_cmd  = 6'b010000; repeat (2) tick();
        power_ok = 1'b0; repeat (2) tick();
        power_ok = 1'b1; repeat (3) tick();

        // Reset in the middle of a gap.
        man_req    = 1'b0;
        auto_alive = 1'b1;
        repeat (3) tick();
        man_req = 1'b1; tick();
        rst_blip();
        repeat (4) tick();

        // Reset held across several edges while in MANUAL.
        rst = 1'b0; repeat (2) tick();
        rst = 1'b1; repeat (2) tick();

        // Randomized traffic.
        repeat (3000) begin
            power_ok    = ($urandom_range(0, 29) != 0);
            auto_enable = ($urandom_range(0, 49) != 0);
            auto_alive  = ($urandom_range(0, 5) == 0);
            if (man_req) man_req = ($urandom_range(0, 9) != 0);
            else man_req = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 14) == 0) auto_req = ~auto_req;
            for (int i = 0; i < 6; i++) begin
                if ($urandom_range(0, 7) == 0) man_cmd[i] = ~man_cmd[i];
                if ($urandom_range(0, 7) == 0) auto_cmd[i] = ~auto_cmd[i];
            end
            if ($urandom_range(0, 499) == 0) rst_blip();
            else tick();
        end

        man_req  = 1'b0;
        auto_req = 1'b0;
        repeat (2) tick();

        checks = checks + 1;
        if (sb_q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL scoreboard_drain pending=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
